// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a combinational ALU: FIFO of tagged commands,
// one-at-a-time issue, and a registered response with valid/ready handshake.
// Optional statistics counters are enabled by defining ALU_SEQ_STATS_EN.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
`ifdef ALU_SEQ_STATS_EN
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_zero,
`endif
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop, capture, rsp_clear, fifo_empty;
  entry_t           head, wr_entry;

  logic [31:0]      alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic [TAG_W-1:0] tag_q;

  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic             rsp_zero_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // cmd_ready depends on the registered count only, so a full FIFO stays closed
  // even in a cycle where the head is popped.
  assign cmd_ready  = (count_q != CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid & cmd_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_entry     = '0;
    wr_entry.a   = cmd_a;
    wr_entry.b   = cmd_b;
    wr_entry.op  = cmd_op;
    wr_entry.tag = cmd_tag;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_clear = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; occupancy is tracked by count_q and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      tag_q    <= '0;
    end else if (pop) begin
      alu_a_q  <= head.a;
      alu_b_q  <= head.b;
      alu_op_q <= head.op;
      tag_q    <= head.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      if (capture) begin
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_tag_q    <= tag_q;
      end else if (rsp_clear) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_tag    = rsp_tag_q;

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_issued_q, stat_zero_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_zero_q   <= '0;
    end else begin
      if (pop)                stat_issued_q <= stat_issued_q + 32'd1;
      if (capture && alu_zero) stat_zero_q  <= stat_zero_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_zero   = stat_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU model attached.
module tb_alu_cmd_sequencer;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [3:0]  rsp_tag;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_issued, stat_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b110,
                         OP_XOR = 3'b100, OP_SLT = 3'b111, OP_SLTU = 3'b011;

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
`ifdef ALU_SEQ_STATS_EN
    .stat_issued(stat_issued),
    .stat_zero  (stat_zero),
`endif
    .rsp_tag    (rsp_tag)
  );

  // Combinational ALU model
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_A & alu_B;
      3'b001: alu_result = alu_A | alu_B;
      3'b010: alu_result = alu_A + alu_B;
      3'b110: alu_result = alu_A - alu_B;
      3'b100: alu_result = alu_A ^ alu_B;
      3'b101: alu_result = ~(alu_A | alu_B);
      3'b111: alu_result = {31'd0, $signed(alu_A) < $signed(alu_B)};
      3'b011: alu_result = {31'd0, alu_A < alu_B};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [3:0] tag, output bit acc);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    acc       = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, samples it, and consumes it if rsp_ready is high.
  task automatic get_rsp(output logic [31:0] res, output logic z, output logic [3:0] tag,
                         output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    res = rsp_result;
    z   = rsp_zero;
    tag = rsp_tag;
    if (ok && rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_tag, alu_A, alu_B, alu_op} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b res=%h z=%0b tag=%0d A=%h B=%h op=%0d, want all 0",
               rsp_valid, rsp_result, rsp_zero, rsp_tag, alu_A, alu_B, alu_op);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_add_latency();
    bit acc;
    rsp_ready = 1'b1;
    send(32'd5, 32'd7, OP_ADD, 4'd3, acc);
    n_cmp++;
    if ({acc, rsp_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL add_accept: got acc=%0b valid=%0b want acc=1 valid=0", acc, rsp_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_early_valid: got %b want 0 one cycle after accept", rsp_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_tag} !== {1'b1, 32'd12, 1'b0, 4'd3}) begin
      n_bad++;
      $display("FAIL add_rsp: got valid=%0b res=%0d z=%0b tag=%0d want valid=1 res=12 z=0 tag=3",
               rsp_valid, rsp_result, rsp_zero, rsp_tag);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_rsp_drop: got valid=%b want 0 after handshake", rsp_valid);
    end
  endtask

  task automatic test_sub_slt_order();
    bit          acc0, acc1, acc2, ok;
    logic [31:0] r;
    logic        z;
    logic [3:0]  t;
    logic [31:0] exp_r [3] = '{32'd0, 32'd1, 32'd0};
    logic        exp_z [3] = '{1'b1, 1'b0, 1'b1};
    rsp_ready = 1'b1;
    send(32'd3, 32'd3, OP_SUB, 4'd0, acc0);
    send(32'hFFFF_FFFF, 32'd1, OP_SLT, 4'd1, acc1);
    send(32'hFFFF_FFFF, 32'd1, OP_SLTU, 4'd2, acc2);
    n_cmp++;
    if ({acc0, acc1, acc2} !== 3'b111) begin
      n_bad++;
      $display("FAIL order_accept: got %b%b%b want 111", acc0, acc1, acc2);
    end
    for (int i = 0; i < 3; i++) begin
      get_rsp(r, z, t, ok);
      n_cmp++;
      if ({ok, r, z, t} !== {1'b1, exp_r[i], exp_z[i], 4'(i)}) begin
        n_bad++;
        $display("FAIL order_rsp%0d: got ok=%0b res=%0d z=%0b tag=%0d want res=%0d z=%0b tag=%0d",
                 i, ok, r, z, t, exp_r[i], exp_z[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          acc [6];
    bit          ok;
    logic [31:0] r;
    logic        z;
    logic [3:0]  t;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(32'(i), 32'd10, OP_ADD, 4'(i), acc[i]);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (acc[i] !== (i < 5)) begin
        n_bad++;
        $display("FAIL bp_accept%0d: got %0b want %0b", i, acc[i], (i < 5));
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({rsp_valid, rsp_result, rsp_tag, cmd_ready} !== {1'b1, 32'd10, 4'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got valid=%0b res=%0d tag=%0d rdy=%0b want 1/10/0/0",
                 k, rsp_valid, rsp_result, rsp_tag, cmd_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(r, z, t, ok);
      n_cmp++;
      if ({ok, r, z, t} !== {1'b1, 32'(i + 10), 1'b0, 4'(i)}) begin
        n_bad++;
        $display("FAIL bp_rsp%0d: got ok=%0b res=%0d z=%0b tag=%0d want res=%0d z=0 tag=%0d",
                 i, ok, r, z, t, i + 10, i);
      end
    end
  endtask

  task automatic test_push_pop_wrap();
    bit          acc [6];
    bit          ok;
    logic [31:0] r;
    logic        z;
    logic [3:0]  t;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'hA5A5_0000 + 32'(i), 32'h0000_5A5A, OP_XOR, 4'(i), acc[i]);
    get_rsp(r, z, t, ok);
    n_cmp++;
    if ({ok, r, t} !== {1'b1, 32'hA5A5_5A5A, 4'd0}) begin
      n_bad++;
      $display("FAIL wrap_head: got ok=%0b res=%h tag=%0d want res=a5a55a5a tag=0", ok, r, t);
    end
    // Pop tag 0 and push tag 4 on the same edge with three entries queued.
    rsp_ready = 1'b1;
    send(32'hA5A5_0004, 32'h0000_5A5A, OP_XOR, 4'd4, acc[4]);
    rsp_ready = 1'b0;
    send(32'hA5A5_0005, 32'h0000_5A5A, OP_XOR, 4'd5, acc[5]);
    n_cmp++;
    if ({acc[0], acc[1], acc[2], acc[3], acc[4], acc[5], cmd_ready} !== 7'b1111110) begin
      n_bad++;
      $display("FAIL wrap_count: got acc=%b%b%b%b%b%b rdy=%b want 111111 rdy=0",
               acc[0], acc[1], acc[2], acc[3], acc[4], acc[5], cmd_ready);
    end
    rsp_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      get_rsp(r, z, t, ok);
      n_cmp++;
      if ({ok, r, t} !== {1'b1, 32'hA5A5_5A5A ^ 32'(i), 4'(i)}) begin
        n_bad++;
        $display("FAIL wrap_rsp%0d: got ok=%0b res=%h tag=%0d want res=%h tag=%0d",
                 i, ok, r, t, 32'hA5A5_5A5A ^ 32'(i), i);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit          acc, seen, ok;
    logic [31:0] r;
    logic        z;
    logic [3:0]  t;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'd1, 32'd2, OP_OR, 4'(i + 8), acc);
    get_rsp(r, z, t, ok);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({ok, rsp_valid, cmd_ready, rsp_result, rsp_tag, alu_A} !== {1'b1, 1'b0, 1'b1, 68'd0}) begin
      n_bad++;
      $display("FAIL midrst_state: got ok=%0b valid=%0b rdy=%0b res=%h tag=%0d A=%h want 1/0/1/0/0/0",
               ok, rsp_valid, cmd_ready, rsp_result, rsp_tag, alu_A);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    seen      = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_stale: got stale rsp_valid=1 want none after reset");
    end
    send(32'd1, 32'd1, OP_ADD, 4'd9, acc);
    get_rsp(r, z, t, ok);
    n_cmp++;
    if ({acc, ok, r, t} !== {1'b1, 1'b1, 32'd2, 4'd9}) begin
      n_bad++;
      $display("FAIL midrst_resume: got acc=%0b ok=%0b res=%0d tag=%0d want 1/1/2/9", acc, ok, r, t);
    end
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    bit          acc, ok0, ok1;
    logic [31:0] r0, r1;
    logic        z0, z1;
    logic [3:0]  t0, t1;
    do_reset();
    rsp_ready = 1'b1;
    send(32'hF0, 32'h0F, OP_AND, 4'd1, acc);
    send(32'd1, 32'd0, OP_OR, 4'd2, acc);
    get_rsp(r0, z0, t0, ok0);
    get_rsp(r1, z1, t1, ok1);
    n_cmp++;
    if ({ok0, r0, z0, ok1, r1, z1} !== {1'b1, 32'd0, 1'b1, 1'b1, 32'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL stats_rsp: got r0=%0d z0=%0b r1=%0d z1=%0b want 0/1 1/0", r0, z0, r1, z1);
    end
    n_cmp++;
    if ({stat_issued, stat_zero} !== {32'd2, 32'd1}) begin
      n_bad++;
      $display("FAIL stats_count: got issued=%0d zero=%0d want 2/1", stat_issued, stat_zero);
    end
  endtask
`endif

  initial begin
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add_latency();
    test_sub_slt_order();
    test_backpressure();
    test_push_pop_wrap();
    test_reset_midflight();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
